// File: rtl/ca_rule_engine.sv
// 1-D elementary cellular-automaton engine: runtime Wolfram rule, four boundary modes,
// free-run or single-step, load/ack handshake per generation. Optional macro: CA_STABLE_DETECT_EN.
module ca_rule_engine #(
  parameter int N      = 16,
  parameter int PERIOD = 1000,
  parameter int GEN_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       rule,
  input  logic [N-1:0]     seed,
  input  logic [1:0]       bmode,
  input  logic             start,
  input  logic             stop,
  input  logic             run,
  input  logic             step,
  input  logic             ack,
  output logic [N-1:0]     cells,
  output logic             load,
  output logic             busy,
  output logic [GEN_W-1:0] generation,
  output logic             stable,
  output logic [7:0]       debug_leds
);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_WAIT, S_COMPUTE} state_t;

  localparam int CW = $clog2(PERIOD + 1);
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);
  localparam int DW = (N < 8) ? N : 8;

  state_t          state_q, state_d;
  logic [N-1:0]    cells_q, cells_d, next_cells;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      rule_q, rule_d;
  logic [1:0]      bmode_q, bmode_d;
  logic            load_q, load_d;
  logic            lb, rb;
  logic [N+1:0]    ext;
`ifdef CA_STABLE_DETECT_EN
  logic            stable_q, stable_d;
`endif

  // Boundary neighbours: lb sits left of cell N-1, rb sits right of cell 0.
  always_comb begin
    unique case (bmode_q)
      2'b00:   begin lb = 1'b0;         rb = 1'b0;         end
      2'b01:   begin lb = 1'b1;         rb = 1'b1;         end
      2'b10:   begin lb = cells_q[0];   rb = cells_q[N-1]; end
      default: begin lb = cells_q[N-1]; rb = cells_q[0];   end
    endcase
    ext = {lb, cells_q, rb};
    for (int i = 0; i < N; i++) begin
      next_cells[i] = rule_q[{ext[i+2], ext[i+1], ext[i]}];
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cells_d  = cells_q;
    gen_d    = gen_q;
    cnt_d    = cnt_q;
    rule_d   = rule_q;
    bmode_d  = bmode_q;
    load_d   = load_q;
`ifdef CA_STABLE_DETECT_EN
    stable_d = stable_q;
`endif
    if (state_q != S_IDLE && stop) begin
      state_d = S_IDLE;
      load_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start && !stop) begin
          rule_d   = rule;
          bmode_d  = bmode;
          cells_d  = seed;
          gen_d    = '0;
          load_d   = 1'b1;
          state_d  = S_PRESENT;
`ifdef CA_STABLE_DETECT_EN
          stable_d = 1'b0;
`endif
        end
        S_PRESENT: if (ack) begin
          load_d  = 1'b0;
          cnt_d   = RELOAD;
`ifdef CA_STABLE_DETECT_EN
          state_d = stable_q ? S_IDLE : S_WAIT;
`else
          state_d = S_WAIT;
`endif
        end
        S_WAIT: begin
          if (run) begin
            if (cnt_q == '0) state_d = S_COMPUTE;
            else             cnt_d   = cnt_q - 1'b1;
          end else if (step) begin
            state_d = S_COMPUTE;
          end
        end
        default: begin
          cells_d = next_cells;
          gen_d   = gen_q + 1'b1;
          load_d  = 1'b1;
          state_d = S_PRESENT;
`ifdef CA_STABLE_DETECT_EN
          if (next_cells == cells_q) stable_d = 1'b1;
`endif
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cells_q  <= '0;
      gen_q    <= '0;
      cnt_q    <= '0;
      rule_q   <= '0;
      bmode_q  <= '0;
      load_q   <= 1'b0;
`ifdef CA_STABLE_DETECT_EN
      stable_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cells_q  <= cells_d;
      gen_q    <= gen_d;
      cnt_q    <= cnt_d;
      rule_q   <= rule_d;
      bmode_q  <= bmode_d;
      load_q   <= load_d;
`ifdef CA_STABLE_DETECT_EN
      stable_q <= stable_d;
`endif
    end
  end

  assign cells      = cells_q;
  assign load       = load_q;
  assign busy       = (state_q != S_IDLE);
  assign generation = gen_q;
  assign debug_leds = 8'(cells_q[DW-1:0]);
`ifdef CA_STABLE_DETECT_EN
  assign stable     = stable_q;
`else
  assign stable     = 1'b0;
`endif

endmodule

// File: tb/tb_ca_rule_engine.sv
// Directed bench for ca_rule_engine (N=8, PERIOD=4) with hand-computed generations.
module tb_ca_rule_engine;

  logic        clk = 1'b0;
  logic        reset_n, start, stop, run, step, ack;
  logic [7:0]  rule, seed, cells, debug_leds;
  logic [1:0]  bmode;
  logic        load, busy, stable;
  logic [15:0] generation;

  int vectors     = 0;
  int miscompares = 0;

  ca_rule_engine #(.N(8), .PERIOD(4), .GEN_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .rule(rule), .seed(seed), .bmode(bmode),
    .start(start), .stop(stop), .run(run), .step(step), .ack(ack),
    .cells(cells), .load(load), .busy(busy), .generation(generation),
    .stable(stable), .debug_leds(debug_leds)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] r, input logic [1:0] b, input logic [7:0] s);
    rule = r; bmode = b; seed = s; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 0; stop = 0; run = 1; step = 0; ack = 0;
    rule = 0; seed = 0; bmode = 0;
    tick(2);
    check("rst_cells", cells, 8'h00);
    check("rst_load", load, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_gen", generation, 16'd0);
    check("rst_stable", stable, 1'b0);
    check("rst_leds", debug_leds, 8'h00);
    reset_n = 1'b1;

    // Rule 90, zero boundary, seed 0x10; inputs scrambled after start must not matter.
    do_start(8'd90, 2'b00, 8'h10);
    rule = 8'h00; seed = 8'hFF; bmode = 2'b11;
    check("g0_load", load, 1'b1);
    check("g0_busy", busy, 1'b1);
    check("g0_cells", cells, 8'h10);
    check("g0_gen", generation, 16'd0);
    ack_pulse();
    check("ack_load_low", load, 1'b0);
    tick(4);
    check("k4_load_low", load, 1'b0);
    tick(1);
    check("k5_load_high", load, 1'b1);
    check("g1_cells", cells, 8'h28);
    check("g1_gen", generation, 16'd1);
    tick(20);
    check("hold_load", load, 1'b1);
    check("hold_cells", cells, 8'h28);
    check("hold_gen", generation, 16'd1);
    ack_pulse();
    tick(5);
    check("g2_cells", cells, 8'h44);
    check("g2_gen", generation, 16'd2);
    check("g2_leds", debug_leds, 8'h44);

    // Stop in WAIT.
    ack_pulse();
    tick(1);
    do_stop();
    check("stop_busy", busy, 1'b0);
    check("stop_load", load, 1'b0);
    check("stop_cells", cells, 8'h44);
    check("stop_gen", generation, 16'd2);
    tick(10);
    check("idle_cells", cells, 8'h44);

    // Wrap boundary, then single-step mode.
    do_start(8'd90, 2'b10, 8'h80);
    ack_pulse();
    tick(5);
    check("wrap_g1", cells, 8'h41);
    run = 1'b0;
    ack_pulse();
    tick(50);
    check("nostep_load", load, 1'b0);
    check("nostep_gen", generation, 16'd1);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    check("step_e1_load", load, 1'b0);
    tick(1);
    check("step_e2_load", load, 1'b1);
    check("step_gen", generation, 16'd2);
    check("wrap_g2", cells, 8'h22);

    // start with stop in IDLE: stop wins.
    do_stop();
    start = 1'b1; stop = 1'b1; rule = 8'd90; bmode = 2'b00; seed = 8'h80;
    tick(1);
    check("startstop_busy", busy, 1'b0);
    stop = 1'b0;
    tick(1);
    start = 1'b0;
    check("restart_busy", busy, 1'b1);
    check("restart_gen", generation, 16'd0);
    run = 1'b1;
    ack_pulse();
    tick(5);
    check("zero_g1", cells, 8'h40);

    // Held step advances only once per WAIT visit.
    run = 1'b0; step = 1'b1;
    ack_pulse();
    tick(10);
    step = 1'b0;
    check("heldstep_gen", generation, 16'd2);
    check("heldstep_cells", cells, 8'hA0);
    check("heldstep_load", load, 1'b1);

    // Reset mid-run.
    ack_pulse();
    tick(2);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("mrst_cells", cells, 8'h00);
    check("mrst_load", load, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_gen", generation, 16'd0);

    // One boundary and reflect boundary.
    run = 1'b1;
    do_start(8'd90, 2'b01, 8'h00);
    ack_pulse();
    tick(5);
    check("one_g1", cells, 8'h81);
    do_stop();
    do_start(8'd90, 2'b11, 8'h01);
    ack_pulse();
    tick(5);
    check("reflect_g1", cells, 8'h03);
    do_stop();

    // Rule 204 is identity: fixed point after one generation.
    do_start(8'd204, 2'b00, 8'hA5);
    check("fp_stable0", stable, 1'b0);
    ack_pulse();
    tick(5);
    check("fp_g1", cells, 8'hA5);
    ack_pulse();
`ifdef CA_STABLE_DETECT_EN
    check("fp_stable", stable, 1'b1);
    check("fp_busy", busy, 1'b0);
`else
    check("fp_stable", stable, 1'b0);
    check("fp_busy", busy, 1'b1);
`endif
    check("fp_load", load, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
